jtkcpu_regs: RTL and testbench

Architectural register file and stack sequencer for JTKCPU, directly downstream of the ALU. Holds A, B, X, Y, U, S and CC, and supplies `opnd0` to the ALU. Commits the ALU result `rslt`/`rslt_hi` and `cc_out` back into the registers. Also sequences multi-register PSH/PUL transfers against memory, one register per handshake.

---
 rtl/jtkcpu_regs.sv | 207 ++++++++++++++++++++
 tb/tb_jtkcpu_regs.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jtkcpu_regs.sv
// JTKCPU architectural registers (A, B, X, Y, U, S, CC) plus the PSH/PUL stack sequencer.
// Defining JTKCPU_REGS_DBG_EN adds a combinational debug read port (dbg_sel/dbg_data).
module jtkcpu_regs #(
  parameter logic [7:0] CC_RST = 8'h50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic [3:0]  src_sel,
  output logic [15:0] opnd0,
  output logic [7:0]  cc,
  input  logic        wb_we,
  input  logic [3:0]  dst_sel,
  input  logic [15:0] rslt,
  input  logic        lmul_we,
  input  logic [15:0] rslt_hi,
  input  logic        cc_we,
  input  logic [7:0]  cc_in,
  input  logic        exg,
  input  logic        tfr,
  input  logic [3:0]  r0_sel,
  input  logic [3:0]  r1_sel,
  input  logic        stk_start,
  input  logic        stk_pull,
  input  logic [7:0]  stk_mask,
  input  logic [15:0] pc_in,
  output logic [15:0] stk_addr,
  output logic [15:0] stk_dout,
  output logic        stk_w16,
  output logic        stk_we,
  output logic        stk_req,
  input  logic        stk_ack,
  input  logic [15:0] stk_din,
  output logic [15:0] pc_out,
  output logic        pc_we,
  output logic        stk_busy
`ifdef JTKCPU_REGS_DBG_EN
  ,
  input  logic [3:0]  dbg_sel,
  output logic [15:0] dbg_data
`endif
);

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] u;
    logic [15:0] s;
    logic [7:0]  cc;
  } rf_t;

  typedef enum logic [1:0] {IDLE, SCAN, XFER} state_t;

  rf_t        rf, rf_n;
  state_t     st;
  logic [7:0] mask_q;
  logic       pull_q;
  logic [2:0] cur_idx, sel_idx;
  logic       sel_any, s_lock;

  function automatic logic [15:0] rd(input rf_t r, input logic [3:0] code);
    case (code)
      4'd0:    return {8'h00, r.a};
      4'd1:    return {8'h00, r.b};
      4'd2:    return r.x;
      4'd3:    return r.y;
      4'd4:    return r.u;
      4'd5:    return r.s;
      4'd6:    return {r.a, r.b};
      4'd7:    return {8'h00, r.cc};
      default: return 16'h0000;
    endcase
  endfunction

  // 8-bit targets keep the low byte; S is protected while the sequencer owns it
  function automatic rf_t wr(input rf_t r, input logic [3:0] code, input logic [15:0] v,
                             input logic lock_s);
    rf_t t;
    t = r;
    case (code)
      4'd0: t.a = v[7:0];
      4'd1: t.b = v[7:0];
      4'd2: t.x = v;
      4'd3: t.y = v;
      4'd4: t.u = v;
      4'd5: if (!lock_s) t.s = v;
      4'd6: begin t.a = v[15:8]; t.b = v[7:0]; end
      4'd7: t.cc = v[7:0];
      default: ;
    endcase
    return t;
  endfunction

  // postbyte bit -> register code; PC and the reserved bit map to a no-write code
  function automatic logic [3:0] bit_code(input logic [2:0] idx);
    case (idx)
      3'd0:    return 4'd7;
      3'd1:    return 4'd0;
      3'd2:    return 4'd1;
      3'd4:    return 4'd2;
      3'd5:    return 4'd3;
      3'd6:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  assign opnd0    = rd(rf, src_sel);
  assign cc       = rf.cc;
  assign stk_addr = rf.s;
  assign sel_any  = |mask_q;
  assign s_lock   = (st != IDLE);

  // push walks from bit 7 down, pull from bit 0 up
  always_comb begin
    sel_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pull_q) begin
        if (mask_q[3'(7 - i)]) sel_idx = 3'(7 - i);
      end else if (mask_q[3'(i)]) begin
        sel_idx = 3'(i);
      end
    end
  end

  // later assignments carry higher priority
  always_comb begin
    rf_n = rf;
    if (exg && (r0_sel != r1_sel))
      rf_n = wr(wr(rf_n, r1_sel, rd(rf, r0_sel), s_lock), r0_sel, rd(rf, r1_sel), s_lock);
    else if (tfr)
      rf_n = wr(rf_n, r1_sel, rd(rf, r0_sel), s_lock);
    if (wb_we) rf_n = wr(rf_n, dst_sel, rslt, s_lock);
    if (cc_we) rf_n.cc = cc_in;
    if (lmul_we) begin
      rf_n.x = rslt_hi;
      rf_n.y = rslt;
    end
    if ((st == SCAN) && sel_any && !pull_q)
      rf_n.s = rf.s - (sel_idx[2] ? 16'd2 : 16'd1);
    if ((st == XFER) && stk_ack && pull_q) begin
      rf_n   = wr(rf_n, bit_code(cur_idx), stk_din, 1'b1);
      rf_n.s = rf.s + (cur_idx[2] ? 16'd2 : 16'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf       <= rf_t'{a: 8'h00, b: 8'h00, x: 16'h0, y: 16'h0, u: 16'h0, s: 16'h0, cc: CC_RST};
      st       <= IDLE;
      mask_q   <= 8'h00;
      pull_q   <= 1'b0;
      cur_idx  <= 3'd0;
      stk_dout <= 16'h0000;
      stk_w16  <= 1'b0;
      stk_we   <= 1'b0;
      stk_req  <= 1'b0;
      pc_out   <= 16'h0000;
      pc_we    <= 1'b0;
      stk_busy <= 1'b0;
    end else if (cen) begin
      rf    <= rf_n;
      pc_we <= 1'b0;
      case (st)
        IDLE: if (stk_start) begin
          mask_q   <= stk_mask & 8'hF7;
          pull_q   <= stk_pull;
          st       <= SCAN;
          stk_busy <= 1'b1;
        end
        SCAN: if (!sel_any) begin
          st       <= IDLE;
          stk_busy <= 1'b0;
        end else begin
          cur_idx          <= sel_idx;
          mask_q[sel_idx]  <= 1'b0;
          stk_req          <= 1'b1;
          stk_we           <= !pull_q;
          stk_w16          <= sel_idx[2];
          stk_dout         <= (sel_idx == 3'd7) ? pc_in : rd(rf, bit_code(sel_idx));
          st               <= XFER;
        end
        XFER: if (stk_ack) begin
          stk_req <= 1'b0;
          stk_we  <= 1'b0;
          if (pull_q && (cur_idx == 3'd7)) begin
            pc_out <= stk_din;
            pc_we  <= 1'b1;
          end
          if (!sel_any) begin
            st       <= IDLE;
            stk_busy <= 1'b0;
          end else begin
            st <= SCAN;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

`ifdef JTKCPU_REGS_DBG_EN
  assign dbg_data = dbg_sel[3] ? {stk_busy, 3'b000, 2'b00, st, 8'h00} : rd(rf, dbg_sel);
`endif

endmodule

// File: tb/tb_jtkcpu_regs.sv
// Self-checking bench for jtkcpu_regs: directed and random register/stack traffic vs a
// per-register priority model and a bit-order stack model.
`timescale 1ns/1ps
module tb_jtkcpu_regs;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b1;
  logic [3:0]  src_sel = 4'd0, dst_sel = 4'd0, r0_sel = 4'd0, r1_sel = 4'd0;
  logic [15:0] opnd0, rslt = 16'h0, rslt_hi = 16'h0, pc_in = 16'h0, stk_din = 16'h0;
  logic [7:0]  cc, cc_in = 8'h0, stk_mask = 8'h0;
  logic        wb_we = 0, lmul_we = 0, cc_we = 0, exg = 0, tfr = 0;
  logic        stk_start = 0, stk_pull = 0, stk_ack = 0;
  logic [15:0] stk_addr, stk_dout, pc_out;
  logic        stk_w16, stk_we, stk_req, pc_we, stk_busy;
`ifdef JTKCPU_REGS_DBG_EN
  logic [3:0]  dbg_sel = 4'd0;
  logic [15:0] dbg_data;
`endif

  always #10 clk = ~clk;

  jtkcpu_regs #(.CC_RST(8'h50)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .src_sel(src_sel), .opnd0(opnd0), .cc(cc),
    .wb_we(wb_we), .dst_sel(dst_sel), .rslt(rslt), .lmul_we(lmul_we), .rslt_hi(rslt_hi),
    .cc_we(cc_we), .cc_in(cc_in), .exg(exg), .tfr(tfr), .r0_sel(r0_sel), .r1_sel(r1_sel),
    .stk_start(stk_start), .stk_pull(stk_pull), .stk_mask(stk_mask), .pc_in(pc_in),
    .stk_addr(stk_addr), .stk_dout(stk_dout), .stk_w16(stk_w16), .stk_we(stk_we),
    .stk_req(stk_req), .stk_ack(stk_ack), .stk_din(stk_din), .pc_out(pc_out),
    .pc_we(pc_we), .stk_busy(stk_busy)
`ifdef JTKCPU_REGS_DBG_EN
    , .dbg_sel(dbg_sel), .dbg_data(dbg_data)
`endif
  );

  int total = 0, bad = 0;
  int busy_obs = 0, pcwe_obs = 0;
  // model: 0 A, 1 B, 2 X, 3 Y, 4 U, 5 S, 6 CC (8-bit ones stored zero-extended)
  logic [15:0] m  [0:6];
  logic [15:0] nv [0:6];
  int          pr [0:6];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (stk_busy) busy_obs++;
    if (pc_we) pcwe_obs++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 7; i++) m[i] = 16'h0;
    m[6] = 16'h0050;
  endtask

  function automatic logic [15:0] mread(input logic [3:0] code);
    case (code)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: return m[code];
      4'd6:    return {m[0][7:0], m[1][7:0]};
      4'd7:    return m[6];
      default: return 16'h0;
    endcase
  endfunction

  task automatic put(input int ph, input logic [15:0] v, input int p);
    if (p > pr[ph]) begin
      pr[ph] = p;
      nv[ph] = (ph == 0 || ph == 1 || ph == 6) ? {8'h00, v[7:0]} : v;
    end
  endtask

  task automatic offer(input logic [3:0] code, input logic [15:0] v, input int p);
    if (code == 4'd6) begin
      put(0, {8'h00, v[15:8]}, p);
      put(1, v, p);
    end else if (code == 4'd7) put(6, v, p);
    else if (code <= 4'd5) put(int'(code), v, p);
  endtask

  // one idle-sequencer cycle using the currently driven inputs
  task automatic step();
    for (int i = 0; i < 7; i++) begin nv[i] = m[i]; pr[i] = 0; end
    if (exg && r0_sel != r1_sel) begin
      offer(r1_sel, mread(r0_sel), 1);
      offer(r0_sel, mread(r1_sel), 1);
    end else if (tfr) offer(r1_sel, mread(r0_sel), 1);
    if (wb_we) offer(dst_sel, rslt, 2);
    if (cc_we) put(6, {8'h00, cc_in}, 3);
    if (lmul_we) begin put(2, rslt_hi, 3); put(3, rslt, 3); end
    tick();
    if (cen) for (int i = 0; i < 7; i++) m[i] = nv[i];
    wb_we = 0; exg = 0; tfr = 0; cc_we = 0; lmul_we = 0; cen = 1;
  endtask

  task automatic chk_all();
    for (int c = 0; c < 8; c++) begin
      src_sel = 4'(c);
      #1;
      chk($sformatf("opnd0[%0d]", c), opnd0, mread(4'(c)));
    end
    chk("cc", {8'h00, cc}, m[6]);
  endtask

  function automatic int phys_of(input int b);
    case (b)
      0: return 6;  1: return 0;  2: return 1;
      4: return 2;  5: return 3;  6: return 4;
      default: return 0;
    endcase
  endfunction

  task automatic run_stack(input logic pull, input logic [7:0] mask, input int dly,
                           input logic [15:0] pcv);
    int order[$];
    int n, b, w, ph, b0, p0;
    logic [15:0] din;
    for (int i = 0; i < 8; i++) begin
      b = pull ? i : 7 - i;
      if (mask[b] && b != 3) order.push_back(b);
    end
    b0 = busy_obs; p0 = pcwe_obs;
    stk_pull = pull; stk_mask = mask; pc_in = pcv; stk_start = 1;
    tick();
    stk_start = 0;
    foreach (order[k]) begin
      b = order[k];
      w = (b >= 4) ? 2 : 1;
      ph = phys_of(b);
      n = 0;
      while (!stk_req && n < 20) begin tick(); n++; end
      chk("req_seen", {15'h0, stk_req}, 16'h1);
      if (!pull) m[5] = m[5] - 16'(w);
      chk("addr", stk_addr, m[5]);
      chk("we", {15'h0, stk_we}, {15'h0, !pull});
      chk("w16", {15'h0, stk_w16}, {15'h0, w == 2});
      if (!pull) chk("dout", stk_dout, (b == 7) ? pcv : m[ph]);
      repeat (dly) tick();
      din = 16'($urandom);
      stk_din = din; stk_ack = 1;
      tick();
      stk_ack = 0;
      if (pull) begin
        if (b == 7) chk("pc_out", pc_out, din);
        else m[ph] = (w == 2) ? din : {8'h00, din[7:0]};
        m[5] = m[5] + 16'(w);
      end
    end
    n = 0;
    while (stk_busy && n < 5) begin tick(); n++; end
    chk("busy_cyc", 16'(busy_obs - b0),
        16'((order.size() == 0) ? 1 : order.size() * (2 + dly)));
    chk("pc_we_cnt", 16'(pcwe_obs - p0), (pull && mask[7]) ? 16'h1 : 16'h0);
    chk("busy_end", {15'h0, stk_busy}, 16'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    model_reset();
    #25;
    chk_all();
    chk("rst_busy", {15'h0, stk_busy}, 16'h0);
    chk("rst_req", {15'h0, stk_req}, 16'h0);
    chk("rst_outs", {11'h0, stk_we, stk_w16, pc_we, stk_req, stk_busy}, 16'h0);
    chk("rst_addr", stk_addr, 16'h0);
    chk("rst_dout", stk_dout, 16'h0);
    chk("rst_pc", pc_out, 16'h0);
    @(negedge clk);
    rst_n = 1;

    wb_we = 1; dst_sel = 4'd6; rslt = 16'h12AB; step(); chk_all();

    wb_we = 1; dst_sel = 4'd2; rslt = 16'h1234; step();
    wb_we = 1; dst_sel = 4'd1; rslt = 16'h0056; step();
    exg = 1; r0_sel = 4'd2; r1_sel = 4'd1;
    wb_we = 1; dst_sel = 4'd1; rslt = 16'h00FF; step(); chk_all();

    cen = 0; wb_we = 1; dst_sel = 4'd0; rslt = 16'h0077; step(); chk_all();

    lmul_we = 1; rslt_hi = 16'hDEAD; rslt = 16'hBEEF; wb_we = 1; dst_sel = 4'd2; step(); chk_all();
    cc_we = 1; cc_in = 8'hA5; wb_we = 1; dst_sel = 4'd7; rslt = 16'h003C;
    tfr = 1; r0_sel = 4'd0; r1_sel = 4'd7; step(); chk_all();

    for (int it = 0; it < 300; it++) begin
      wb_we = 1'($urandom); dst_sel = 4'($urandom); rslt = 16'($urandom);
      lmul_we = ($urandom_range(0, 5) == 0); rslt_hi = 16'($urandom);
      cc_we = ($urandom_range(0, 3) == 0); cc_in = 8'($urandom);
      r0_sel = 4'($urandom); r1_sel = 4'($urandom);
      k = $urandom_range(0, 3); exg = (k == 1); tfr = (k == 2);
      if (exg && ((r0_sel == 4'd6 && r1_sel < 4'd2) || (r1_sel == 4'd6 && r0_sel < 4'd2))) exg = 0;
      cen = ($urandom_range(0, 7) != 0);
      step();
      chk_all();
    end

    wb_we = 1; dst_sel = 4'd5; rslt = 16'h0100; step();
    run_stack(1'b0, 8'hB3, 0, 16'hC0DE); chk_all();
    run_stack(1'b1, 8'h81, 0, 16'h0000); chk_all();

    wb_we = 1; dst_sel = 4'd5; rslt = 16'h0040; step();
    stk_pull = 0; stk_mask = 8'h02; stk_start = 1; tick(); stk_start = 0;
    wb_we = 1; dst_sel = 4'd5; rslt = 16'h1234; tick(); wb_we = 0;
    m[5] = m[5] - 16'd1;
    wb_we = 1; dst_sel = 4'd2; rslt = 16'hABCD; tick(); wb_we = 0;
    m[2] = 16'hABCD;
    chk("busy_s_lock", stk_addr, m[5]);
    chk_all();
    stk_ack = 1; tick(); stk_ack = 0;
    chk("busy_drop", {15'h0, stk_busy}, 16'h0);

    for (int it = 0; it < 20; it++) begin
      wb_we = 1; dst_sel = 4'd5; rslt = 16'h4000 + 16'($urandom_range(0, 255)); step();
      run_stack(1'($urandom), 8'($urandom), $urandom_range(0, 2), 16'($urandom));
      chk_all();
    end
    run_stack(1'b0, 8'h08, 0, 16'h0000);

    wb_we = 1; dst_sel = 4'd5; rslt = 16'h0200; step();
    stk_pull = 0; stk_mask = 8'hF0; stk_start = 1; tick(); stk_start = 0;
    tick();
    chk("pre_rst_req", {15'h0, stk_req}, 16'h1);
    rst_n = 0;
    #2;
    model_reset();
    chk("abort_req", {15'h0, stk_req}, 16'h0);
    chk("abort_busy", {15'h0, stk_busy}, 16'h0);
    chk_all();
    @(negedge clk);
    rst_n = 1;
    tick();
    chk("post_rst_busy", {15'h0, stk_busy}, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
